// File: rtl/output_2_packer.sv
// Binarized-vector packer: sign-binarizes LANES signed activations per beat
// against THRESH, packs them LSB-first into a VEC_W vector and emits the
// completed vector with a one-cycle valid pulse. Never stalls.
module output_2_packer #(
    parameter int                        DATA_W = 16,
    parameter int                        LANES  = 8,
    parameter int                        VEC_W  = 256,
    parameter logic signed [DATA_W-1:0]  THRESH = '0,
    localparam int                       BEATS  = VEC_W / LANES,
    localparam int                       CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES*DATA_W-1:0]   act_in,
    input  logic                      act_in_valid,
    input  logic                      act_in_last,
    output logic [VEC_W-1:0]          data_out,
    output logic                      data_out_valid,
    output logic [CNT_W-1:0]          beat_cnt,
    output logic                      err_short
);

    // Accumulates the bits of the vector currently being collected.
    logic [VEC_W-1:0] acc_p0;
    logic [LANES-1:0] bits_p0;
    logic [VEC_W-1:0] merged_p0;
    logic             last_beat_p0;
    logic             close_p0;

    // One bit per lane: set when the activation is at or above the threshold.
    function automatic logic [LANES-1:0] binarize(input logic [LANES*DATA_W-1:0] acts);
        logic [LANES-1:0]         bits;
        logic signed [DATA_W-1:0] a;
        bits = '0;
        for (int k = 0; k < LANES; k++) begin
            a       = acts[k*DATA_W +: DATA_W];
            bits[k] = (a >= THRESH);
        end
        return bits;
    endfunction

    // Merge the current beat into the accumulated vector and detect the closing beat.
    always_comb begin
        bits_p0      = binarize(act_in);
        last_beat_p0 = (beat_cnt == CNT_W'(BEATS - 1));
        close_p0     = act_in_valid && (act_in_last || last_beat_p0);
        merged_p0    = acc_p0;
        merged_p0[beat_cnt*LANES +: LANES] = bits_p0;
    end

    // ---- stage p0 -> output register: accumulate, or emit and restart ----
    // Collect beats; on the closing beat register the full vector and pulse valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_p0         <= '0;
            beat_cnt       <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            err_short      <= 1'b0;
        end else begin
            data_out_valid <= close_p0;
            err_short      <= close_p0 && !last_beat_p0;
            if (act_in_valid) begin
                if (close_p0) begin
                    data_out <= merged_p0;
                    acc_p0   <= '0;
                    beat_cnt <= '0;
                end else begin
                    acc_p0   <= merged_p0;
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_output_2_packer.sv
// Self-checking bench for output_2_packer: directed sequences, a vector table
// and randomized traffic compared against a bit-level reference model.
module tb_output_2_packer;

    localparam int DATA_W = 16;
    localparam int LANES  = 8;
    localparam int VEC_W  = 256;
    localparam int BEATS  = VEC_W / LANES;
    localparam int THRESH = 0;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [LANES*DATA_W-1:0] act_in;
    logic                    act_in_valid;
    logic                    act_in_last;
    logic [VEC_W-1:0]        data_out;
    logic                    data_out_valid;
    logic [4:0]              beat_cnt;
    logic                    err_short;

    output_2_packer #(.DATA_W(DATA_W), .LANES(LANES), .VEC_W(VEC_W), .THRESH('0)) dut (
        .clk(clk), .rst_n(rst_n), .act_in(act_in), .act_in_valid(act_in_valid),
        .act_in_last(act_in_last), .data_out(data_out), .data_out_valid(data_out_valid),
        .beat_cnt(beat_cnt), .err_short(err_short)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pulses[$];

    // Reference model state
    logic [VEC_W-1:0] m_vec;
    int               m_fill;
    logic [VEC_W-1:0] m_out;
    logic             m_vld;
    logic             m_err;

    typedef struct {
        logic [LANES*DATA_W-1:0] act;
        bit                      vld;
        bit                      last;
        bit                      exp_vld;
        bit                      exp_err;
        int                      exp_cnt;
        logic [VEC_W-1:0]        exp_out;
    } vec_t;

    task automatic chk(input string name, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %h required %h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [LANES*DATA_W-1:0] pack_all(input logic [DATA_W-1:0] v);
        return {LANES{v}};
    endfunction

    // Model: every accepted beat writes its lanes into the next LANES bit slots.
    task automatic model_step(input logic [LANES*DATA_W-1:0] acts, input bit v, input bit l, input bit rn);
        logic signed [DATA_W-1:0] a;
        if (!rn) begin
            m_vec = '0; m_fill = 0; m_out = '0; m_vld = 0; m_err = 0;
            return;
        end
        m_vld = 0;
        m_err = 0;
        if (v) begin
            for (int k = 0; k < LANES; k++) begin
                a = acts[k*DATA_W +: DATA_W];
                m_vec[m_fill*LANES + k] = (int'(a) >= THRESH);
            end
            m_fill++;
            if (l || m_fill == BEATS) begin
                m_out  = m_vec;
                m_vld  = 1;
                m_err  = (m_fill < BEATS);
                m_vec  = '0;
                m_fill = 0;
            end
        end
    endtask

    task automatic drive(input logic [LANES*DATA_W-1:0] acts, input bit v, input bit l, input bit rn);
        act_in = acts; act_in_valid = v; act_in_last = l; rst_n = rn;
        model_step(acts, v, l, rn);
        @(posedge clk);
        #1;
        cyc++;
        if (data_out_valid === 1'b1) pulses.push_back(cyc);
        chk("model_data_out", data_out, m_out);
        chk("model_valid", VEC_W'(data_out_valid), VEC_W'(m_vld));
        chk("model_err_short", VEC_W'(err_short), VEC_W'(m_err));
        chk("model_beat_cnt", VEC_W'(beat_cnt), VEC_W'(m_fill));
    endtask

    logic [VEC_W-1:0] ones;
    logic [LANES*DATA_W-1:0] alt_m1_p1;
    logic [LANES*DATA_W-1:0] alt_0_m1;
    logic [LANES*DATA_W-1:0] racts;
    vec_t tbl[7];

    initial begin
        ones      = '1;
        alt_m1_p1 = {4{16'h0001, 16'hFFFF}};   // even lanes -1, odd lanes +1
        alt_0_m1  = {4{16'hFFFF, 16'h0000}};   // even lanes 0, odd lanes -1
        m_vec = '0; m_fill = 0; m_out = '0; m_vld = 0; m_err = 0;
        rst_n = 0; act_in = '0; act_in_valid = 0; act_in_last = 0;

        // Reset state
        drive(pack_all(16'd5), 1, 1, 0);
        chk("reset_data_out", data_out, '0);
        chk("reset_valid", VEC_W'(data_out_valid), '0);
        chk("reset_beat_cnt", VEC_W'(beat_cnt), '0);
        chk("reset_err", VEC_W'(err_short), '0);

        // Full vector of +5
        for (int b = 0; b < BEATS; b++) drive(pack_all(16'd5), 1, 0, 1);
        chk("plus5_data", data_out, ones);
        chk("plus5_valid", VEC_W'(data_out_valid), VEC_W'(1));
        chk("plus5_err", VEC_W'(err_short), '0);
        chk("plus5_cnt", VEC_W'(beat_cnt), '0);
        drive('0, 0, 0, 1);
        chk("hold_valid_low", VEC_W'(data_out_valid), '0);
        chk("hold_data", data_out, ones);

        // Alternating -1/+1 gives 0xAA pattern
        for (int b = 0; b < BEATS; b++) drive(alt_m1_p1, 1, 0, 1);
        chk("alt_data", data_out, {32{8'hAA}});
        chk("alt_valid", VEC_W'(data_out_valid), VEC_W'(1));

        // Table: threshold boundary, early last on beat 3, last ignored when idle
        tbl[0] = '{alt_0_m1,           1, 1, 1, 1, 0, 256'h55};
        tbl[1] = '{pack_all(16'd1),    1, 0, 0, 0, 1, 256'h55};
        tbl[2] = '{pack_all(16'd1),    1, 0, 0, 0, 2, 256'h55};
        tbl[3] = '{pack_all(16'd1),    1, 0, 0, 0, 3, 256'h55};
        tbl[4] = '{pack_all(16'd1),    1, 1, 1, 1, 0, 256'hFFFFFFFF};
        tbl[5] = '{pack_all(16'hFFFF), 0, 1, 0, 0, 0, 256'hFFFFFFFF};
        tbl[6] = '{pack_all(16'd1),    1, 0, 0, 0, 1, 256'hFFFFFFFF};
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].act, tbl[i].vld, tbl[i].last, 1);
            chk($sformatf("tbl%0d_data", i), data_out, tbl[i].exp_out);
            chk($sformatf("tbl%0d_valid", i), VEC_W'(data_out_valid), VEC_W'(tbl[i].exp_vld));
            chk($sformatf("tbl%0d_err", i), VEC_W'(err_short), VEC_W'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_cnt", i), VEC_W'(beat_cnt), VEC_W'(tbl[i].exp_cnt));
        end
        drive('0, 0, 0, 0);

        // Back-to-back vectors, no bubble
        pulses.delete();
        for (int b = 0; b < BEATS; b++) drive(pack_all(16'd1), 1, 0, 1);
        chk("b2b_first", data_out, ones);
        for (int b = 0; b < BEATS; b++) drive(pack_all(16'hFFFF), 1, 0, 1);
        chk("b2b_second", data_out, '0);
        chk("b2b_second_valid", VEC_W'(data_out_valid), VEC_W'(1));
        chk("b2b_pulse_count", VEC_W'(pulses.size()), VEC_W'(2));
        if (pulses.size() == 2) chk("b2b_spacing", VEC_W'(pulses[1] - pulses[0]), VEC_W'(32));

        // Valid toggling: idle cycles ignored
        pulses.delete();
        for (int i = 0; i < 2*BEATS; i++) drive(pack_all(16'd1), (i % 2) == 0, 0, 1);
        chk("toggle_pulse_count", VEC_W'(pulses.size()), VEC_W'(1));
        chk("toggle_data", data_out, ones);

        // Reset mid-vector discards partial bits
        drive('0, 0, 0, 0);
        pulses.delete();
        for (int b = 0; b < 10; b++) drive(pack_all(16'd1), 1, 0, 1);
        drive(pack_all(16'd1), 1, 0, 0);
        chk("midrst_cnt", VEC_W'(beat_cnt), '0);
        for (int b = 0; b < BEATS; b++) drive(pack_all(16'd1), 1, 0, 1);
        chk("midrst_pulse_count", VEC_W'(pulses.size()), VEC_W'(1));
        chk("midrst_data", data_out, ones);

        // Reset on the closing beat suppresses the pulse
        drive(pack_all(16'd0), 1, 1, 1);
        for (int b = 0; b < BEATS-1; b++) drive(pack_all(16'd1), 1, 0, 1);
        drive(pack_all(16'd1), 1, 0, 0);
        chk("rstwin_valid", VEC_W'(data_out_valid), '0);
        chk("rstwin_data", data_out, '0);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < LANES; k++) begin
                case ($urandom_range(0, 3))
                    0:       racts[k*DATA_W +: DATA_W] = 16'h0000;
                    1:       racts[k*DATA_W +: DATA_W] = 16'hFFFF;
                    default: racts[k*DATA_W +: DATA_W] = 16'($urandom);
                endcase
            end
            drive(racts, ($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 64) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
